// File: rtl/multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : multdiv_ctrl
//  Description : Multi-cycle MULT/MULTU/DIV/DIVU unit with HI/LO result
//                registers, stall request and flush abort.
//  Revision    : 1.0 - initial release
// ============================================================================
module multdiv_ctrl #(
    parameter int MULT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        valid,
    input  logic [1:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_mul   = 2'd1;
    localparam logic [1:0] c_st_div   = 2'd2;
    localparam logic [1:0] c_st_fix   = 2'd3;
    localparam logic [4:0] c_mul_last = 5'(MULT_CYCLES - 1);
    localparam logic [4:0] c_div_last = 5'd31;

    logic [1:0]  r_state;
    logic [1:0]  w_next;
    logic [4:0]  r_cnt;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic        r_signed;
    logic [31:0] r_quo;
    logic [31:0] r_rem;
    logic [31:0] r_div;
    logic        r_done;
    logic [31:0] r_hi;
    logic [31:0] r_lo;

    logic        w_accept;
    logic        w_commit;
    logic [63:0] w_a_ext;
    logic [63:0] w_b_ext;
    logic [63:0] w_prod;
    logic [32:0] w_trial;
    logic [32:0] w_diff;
    logic [31:0] w_hi;
    logic [31:0] w_lo;

    assign w_accept = (r_state == c_st_idle) & valid & ~flush;
    assign w_commit = ~flush & (((r_state == c_st_mul) & (r_cnt == c_mul_last)) |
                                (r_state == c_st_fix));

    assign busy = w_accept | (r_state != c_st_idle);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

    // Sign/zero extension to 64 bits makes one multiplier serve both MULT and MULTU.
    assign w_a_ext = {{32{r_signed & r_a[31]}}, r_a};
    assign w_b_ext = {{32{r_signed & r_b[31]}}, r_b};
    assign w_prod  = w_a_ext * w_b_ext;

    assign w_trial = {r_rem, r_quo[31]};
    assign w_diff  = w_trial - {1'b0, r_div};

    always_comb begin
        w_hi = w_prod[63:32];
        w_lo = w_prod[31:0];
        if (r_state != c_st_mul) begin
            if (r_b == 32'd0) begin
                w_hi = r_a;
                w_lo = 32'hFFFF_FFFF;
            end else begin
                w_lo = (r_signed & (r_a[31] ^ r_b[31])) ? -r_quo : r_quo;
                w_hi = (r_signed & r_a[31]) ? -r_rem : r_rem;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_st_idle: if (w_accept) w_next = op[1] ? c_st_div : c_st_mul;
            c_st_mul:  if (flush || (r_cnt == c_mul_last)) w_next = c_st_idle;
            c_st_div: begin
                if (flush)                    w_next = c_st_idle;
                else if (r_cnt == c_div_last) w_next = c_st_fix;
            end
            c_st_fix:  w_next = c_st_idle;
            default:   w_next = c_st_idle;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= c_st_idle;
        else         r_state <= w_next;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt    <= 5'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_signed <= 1'b0;
            r_quo    <= 32'd0;
            r_rem    <= 32'd0;
            r_div    <= 32'd0;
            r_done   <= 1'b0;
            r_hi     <= 32'd0;
            r_lo     <= 32'd0;
        end else begin
            r_done <= w_commit;
            if (w_commit) begin
                r_hi <= w_hi;
                r_lo <= w_lo;
            end
            if (w_accept) begin
                r_a      <= a;
                r_b      <= b;
                r_signed <= ~op[0];
                r_cnt    <= 5'd0;
                r_rem    <= 32'd0;
                r_quo    <= (~op[0] & a[31]) ? -a : a;
                r_div    <= (~op[0] & b[31]) ? -b : b;
            end else if (r_state == c_st_mul) begin
                r_cnt <= r_cnt + 5'd1;
            end else if (r_state == c_st_div) begin
                r_cnt <= r_cnt + 5'd1;
                // Restoring step: keep the subtraction only if it did not go negative.
                if (!w_diff[32]) begin
                    r_rem <= w_diff[31:0];
                    r_quo <= {r_quo[30:0], 1'b1};
                end else begin
                    r_rem <= w_trial[31:0];
                    r_quo <= {r_quo[30:0], 1'b0};
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_multdiv_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_multdiv_ctrl
//  Description : Directed and random self-checking bench for multdiv_ctrl.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_multdiv_ctrl;

    localparam int MULT_CYCLES = 2;
    localparam int DIV_LAT     = 33;

    logic        clk    = 1'b0;
    logic        resetn = 1'b0;
    logic        valid  = 1'b0;
    logic        flush  = 1'b0;
    logic [1:0]  op     = 2'b00;
    logic [31:0] a      = 32'd0;
    logic [31:0] b      = 32'd0;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int          n_vec = 0;
    int          n_err = 0;
    logic [63:0] sb_q[$];
    logic [63:0] last_res = 64'd0;

    always #5 clk = ~clk;

    multdiv_ctrl #(.MULT_CYCLES(MULT_CYCLES)) dut (
        .clk   (clk),
        .resetn(resetn),
        .valid (valid),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    // Reference results {hi, lo} computed with native 64-bit arithmetic.
    function automatic logic [63:0] model(input logic [1:0] mop, input logic [31:0] ma,
                                          input logic [31:0] mb);
        longint sa;
        longint sb;
        longint q;
        longint r;
        logic [63:0] res;
        if (mop[0]) begin
            sa = longint'({32'd0, ma});
            sb = longint'({32'd0, mb});
        end else begin
            sa = longint'($signed(ma));
            sb = longint'($signed(mb));
        end
        if (!mop[1]) begin
            res = 64'(sa * sb);
        end else if (mb == 32'd0) begin
            res = {ma, 32'hFFFF_FFFF};
        end else begin
            q   = sa / sb;
            r   = sa % sb;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h required %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drive one request in the current cycle; returns in the cycle after the accepting edge.
    task automatic start(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        valid = 1'b1;
        op    = o;
        a     = x;
        b     = y;
        #1;
        check("busy_accept", {63'd0, busy}, 64'd1);
        sb_q.push_back(model(o, x, y));
        @(posedge clk);
        #1;
        valid = 1'b0;
        op    = 2'($urandom_range(0, 3));
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input int lat, input bit flush_in_done);
        int          n;
        bit          busy_ok;
        logic [63:0] exp;
        n       = 0;
        busy_ok = 1'b1;
        check("hold_prior", {hi, lo}, last_res);
        while (done !== 1'b1 && n < 100) begin
            if (busy !== 1'b1) busy_ok = 1'b0;
            tick();
            n++;
        end
        check("latency", 64'(n), 64'(lat));
        check("busy_while_running", {63'd0, busy_ok}, 64'd1);
        check("busy_in_done", {63'd0, busy}, 64'd0);
        if (sb_q.size() == 0) begin
            check("scoreboard_empty", 64'(sb_q.size()), 64'd1);
        end else begin
            exp = sb_q.pop_front();
            check("result", {hi, lo}, exp);
            last_res = exp;
        end
        if (flush_in_done) flush = 1'b1;
        tick();
        flush = 1'b0;
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("hold_after_done", {hi, lo}, last_res);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0]  ro;
        logic [31:0] rx;
        logic [31:0] ry;
        int          pulses;

        // Reset state
        #3;
        check("reset_busy", {63'd0, busy}, 64'd0);
        check("reset_done", {63'd0, done}, 64'd0);
        check("reset_hilo", {hi, lo}, 64'd0);
        #9;
        resetn = 1'b1;

        // First request right after reset release, signed multiply
        start(2'b00, 32'hFFFF_FFFD, 32'd5);
        wait_done(MULT_CYCLES, 1'b0);
        check("mult_neg_const", last_res, 64'hFFFF_FFFF_FFFF_FFF1);

        // Back-to-back: MULTU in the cycle right after the previous done
        start(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(MULT_CYCLES, 1'b0);
        check("multu_const", last_res, 64'hFFFF_FFFE_0000_0001);

        start(2'b10, 32'hFFFF_FFF9, 32'd2);
        wait_done(DIV_LAT, 1'b0);
        check("div_neg_const", last_res, 64'hFFFF_FFFF_FFFF_FFFD);

        start(2'b11, 32'd100, 32'd0);
        wait_done(DIV_LAT, 1'b0);
        check("divu_zero_const", last_res, 64'h0000_0064_FFFF_FFFF);

        start(2'b10, 32'hFFFF_FFFB, 32'd0);
        wait_done(DIV_LAT, 1'b0);

        start(2'b10, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(DIV_LAT, 1'b0);
        check("div_ovf_const", last_res, 64'h0000_0000_8000_0000);

        start(2'b10, 32'd7, 32'hFFFF_FFFE);
        wait_done(DIV_LAT, 1'b0);

        start(2'b11, 32'hFFFF_FFFF, 32'd3);
        wait_done(DIV_LAT, 1'b0);

        start(2'b00, 32'h8000_0000, 32'h8000_0000);
        wait_done(MULT_CYCLES, 1'b0);

        // valid while busy is ignored; flush in the done cycle is harmless
        start(2'b11, 32'd1000, 32'd7);
        repeat (3) tick();
        valid = 1'b1;
        op    = 2'b00;
        a     = 32'd5;
        b     = 32'd5;
        tick();
        tick();
        valid = 1'b0;
        wait_done(DIV_LAT - 5, 1'b1);

        // flush together with valid in IDLE
        valid = 1'b1;
        flush = 1'b1;
        op    = 2'b00;
        #1;
        check("flush_valid_busy", {63'd0, busy}, 64'd0);
        tick();
        valid = 1'b0;
        flush = 1'b0;
        #1;
        check("flush_valid_not_accepted", {63'd0, busy}, 64'd0);
        tick();

        // Flush mid-divide, then MULT 3*4
        start(2'b10, 32'd1000, 32'd3);
        repeat (10) tick();
        flush = 1'b1;
        #1;
        check("flush_cycle_busy", {63'd0, busy}, 64'd1);
        check("flush_cycle_done", {63'd0, done}, 64'd0);
        tick();
        flush = 1'b0;
        check("after_flush_busy", {63'd0, busy}, 64'd0);
        check("after_flush_done", {63'd0, done}, 64'd0);
        check("after_flush_hilo", {hi, lo}, last_res);
        void'(sb_q.pop_back());
        start(2'b00, 32'd3, 32'd4);
        wait_done(MULT_CYCLES, 1'b0);
        check("mult_3x4_const", last_res, 64'd12);

        // Asynchronous reset in the middle of a DIVU
        start(2'b11, 32'd500, 32'd7);
        repeat (5) tick();
        #2;
        resetn = 1'b0;
        #1;
        check("midop_reset_busy", {63'd0, busy}, 64'd0);
        check("midop_reset_done", {63'd0, done}, 64'd0);
        check("midop_reset_hilo", {hi, lo}, 64'd0);
        last_res = 64'd0;
        void'(sb_q.pop_back());
        #2;
        resetn = 1'b1;
        pulses = 0;
        repeat (40) begin
            tick();
            if (done === 1'b1) pulses++;
        end
        check("no_done_after_reset", 64'(pulses), 64'd0);

        // Random mix
        for (int i = 0; i < 8; i++) begin
            ro = 2'($urandom_range(0, 3));
            rx = $urandom;
            ry = (i == 3) ? 32'd0 : $urandom;
            start(ro, rx, ry);
            wait_done(ro[1] ? DIV_LAT : MULT_CYCLES, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/multdiv_ctrl.md
MULTDIV_CTRL -- requirements
Module: multdiv_ctrl

Interface
REQ-001 Parameter MULT_CYCLES, default 2, gives the cycles from acceptance to done for MULT/MULTU; legal range 1..4.
REQ-002 clk  input  1  rising-edge clock; the block's only clock.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 valid  input  1  start request from the execute stage.
REQ-005 op  input  2  operation: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU.
REQ-006 a  input  32  rs operand (multiplicand / dividend).
REQ-007 b  input  32  rt operand (multiplier / divisor).
REQ-008 flush  input  1  abort any in-flight operation (exception or ERET).
REQ-009 busy  output  1  pipeline stall request.
REQ-010 done  output  1  one-cycle pulse; hi/lo are valid that cycle.
REQ-011 hi  output  32  HI result (product high word / remainder).
REQ-012 lo  output  32  LO result (product low word / quotient).

Function
REQ-013 FSM states: IDLE, MUL, DIV, FIX.
- MUL counts MULT_CYCLES.
- DIV runs 32 restoring iterations.
- FIX applies the sign correction.
REQ-014 Acceptance: valid=1 and flush=0 in IDLE accepts; operands a, b and op are latched on that edge.
REQ-015 Transition on accept: IDLE->MUL for op[1]=0; IDLE->DIV for op[1]=1.
REQ-016 busy is combinational, equal to (IDLE & valid & ~flush) | MUL | DIV | FIX, so a stall is raised in the acceptance cycle itself.
REQ-017 MUL timing: accept at edge T; done=1 in cycle T+MULT_CYCLES with busy=0; next state IDLE.
REQ-018 DIV timing: 32 DIV cycles, then FIX; done=1 in cycle T+33 with busy=0; next state IDLE.
REQ-019 MULT: 64-bit signed product of a and b; hi = [63:32], lo = [31:0].
REQ-020 MULTU: 64-bit unsigned product; hi = [63:32], lo = [31:0].
REQ-021 DIVU: unsigned restoring division; lo = quotient, hi = remainder.
REQ-022 DIV operands: |a| and |b| are divided unsigned.
REQ-023 DIV result signs:
- quotient negated when a[31]^b[31];
- remainder takes the sign of a.
REQ-024 Divide by zero (DIV or DIVU): lo = 32'hFFFF_FFFF and hi = a; latency unchanged.
REQ-025 DIV of 32'h8000_0000 by 32'hFFFF_FFFF: lo = 32'h8000_0000, hi = 0.
REQ-026 hi/lo update only on the done edge and hold until the next done.
REQ-027 valid while busy (non-IDLE) is ignored and does not restart or alter the operation.
REQ-028 flush=1 in any non-IDLE state:
- next state is IDLE;
- no done pulse is produced;
- hi/lo are unchanged;
- busy deasserts in the following cycle.
REQ-029 flush and valid asserted together in IDLE: flush wins, nothing is accepted and busy=0.
REQ-030 flush in the done cycle has no effect: that result is already committed.
REQ-031 A new valid in the cycle after done is accepted normally (back-to-back operations).

Reset
REQ-032 resetn=0 forces, asynchronously:
- state = IDLE;
- iteration counter = 0;
- done = 0;
- hi = 0 and lo = 0;
- busy = 0 (busy also requires valid=0 while in IDLE).
REQ-033 Reset mid-operation discards the in-flight result.
REQ-034 The first acceptance after reset release takes effect on the first rising edge with resetn=1.

Verification
REQ-035 MULT, a=32'hFFFF_FFFD, b=5 -> at T+2: hi=32'hFFFF_FFFF, lo=32'hFFFF_FFF1, done=1 for exactly one cycle.
REQ-036 MULTU, a=b=32'hFFFF_FFFF -> at T+2: hi=32'hFFFF_FFFE, lo=32'h0000_0001.
REQ-037 DIV, a=32'hFFFF_FFF9 (-7), b=2 -> busy=1 for cycles T..T+32; done at T+33 with lo=32'hFFFF_FFFD, hi=32'hFFFF_FFFF.
REQ-038 DIVU, a=100, b=0 -> at T+33: lo=32'hFFFF_FFFF, hi=32'h0000_0064.
REQ-039 DIV started, flush at T+10 -> busy=0 from T+11, no done, hi/lo retain the prior values; a new MULT 3*4 issued at T+12 -> done at T+14 with lo=12.
REQ-040 resetn pulsed low at T+5 of a DIVU -> immediately busy=0, hi=lo=0; no done pulse ever appears for that operation.
